byte_block_packer: RTL
======================

BYTE_BLOCK_PACKER -- requirements
Module: byte_block_packer

Interface
REQ-001 The block SHALL have these parameters:
  - BYTE_W, default 8, width of one input unit in bits.
  - NUM_BYTES, default 16, number of units per output block (2..64).
  - MSB_FIRST, default 1. 1: the first accepted unit lands in the top unit of out_data. 0: it lands in bits [BYTE_W-1:0].
  - PAD_BYTE, default 8'h00, fill value for unused positions on flush.
REQ-002 The block SHALL have these ports:
  - Clk  in  1  clock; all state changes on the rising edge.
  - Rst  in  1  reset, synchronous, active-high.
  - Enable  in  1  high = accumulate; low = discard the partial block.
  - in_data  in  BYTE_W  input unit.
  - in_valid  in  1  in_data valid.
  - in_ready  out  1  unit accepted at this edge when in_valid && in_ready.
  - flush  in  1  emit the partial block, padded.
  - out_data  out  NUM_BYTES*BYTE_W  assembled block.
  - out_valid  out  1  out_data/out_count valid.
  - out_ready  in  1  consumer takes the block at this edge when out_valid && out_ready.
  - out_count  out  clog2(NUM_BYTES+1)  number of real units in the block; NUM_BYTES when full.
  - fill_level  out  clog2(NUM_BYTES+1)  units currently held in the accumulator.

Function
REQ-003 The block SHALL hold a separate accumulator and output register, so filling continues while an emitted block awaits out_ready.
REQ-004 The accumulator state machine SHALL have three states:
  - EMPTY: fill_level=0.
  - FILLING: 0<fill_level<NUM_BYTES.
  - STALL: fill_level=NUM_BYTES, transfer blocked.
REQ-005 in_ready SHALL be combinational: Enable && state!=STALL.
REQ-006 Each accepted unit SHALL be stored at position fill_level in the ordering selected by MSB_FIRST, and fill_level SHALL increment by 1.
REQ-007 The output register is free in a cycle when out_valid==0 or out_ready==1.
REQ-008 When the NUM_BYTES-th unit is accepted and the output register is free, at that same edge:
  - the block SHALL move to the output register;
  - out_valid SHALL be set and out_count SHALL be NUM_BYTES;
  - the accumulator SHALL return to EMPTY.
  Latency: out_valid is visible the cycle after the last unit is accepted.
REQ-009 When the NUM_BYTES-th unit is accepted and the output register is not free, the accumulator SHALL enter STALL. It SHALL transfer at the first edge the output register is free, then return to EMPTY.
REQ-010 While out_valid=1 and out_ready=0, out_data and out_count SHALL remain stable.
REQ-011 When out_valid && out_ready and no transfer happens at that edge, out_valid SHALL clear.
REQ-012 Back-to-back blocks SHALL sustain one unit per cycle when out_ready is held high.
REQ-013 flush=1 with Enable=1 in FILLING SHALL treat the partial block as complete:
  - positions fill_level..NUM_BYTES-1 SHALL be PAD_BYTE;
  - out_count SHALL be fill_level, including any unit accepted in the same cycle;
  - the transfer rules of REQ-008 and REQ-009 SHALL apply.
REQ-014 flush in EMPTY SHALL be ignored. flush in STALL SHALL be ignored, since the block is already full.
REQ-015 flush together with acceptance of the NUM_BYTES-th unit SHALL produce one full block (out_count=NUM_BYTES) and no empty block.
REQ-016 Enable=0 SHALL clear the accumulator to EMPTY at the next edge, discarding partial and STALL contents, with in_ready=0. The output register and out_valid SHALL be unaffected, so a pending block is still delivered.
REQ-017 Transfer to the output register and consumption of the previous block at the same edge (out_ready=1) SHALL lose no block.
REQ-018 fill_level SHALL never exceed NUM_BYTES and SHALL wrap to 0 only through transfer, Enable=0 or Rst.

Reset
REQ-019 While Rst=1 at an edge, the block SHALL:
  - enter EMPTY with fill_level=0;
  - clear out_valid, out_data and out_count to 0;
  - set the accumulator contents to PAD_BYTE in every position.
REQ-020 Rst SHALL take priority over Enable, flush and all handshakes.
REQ-021 Rst mid-block SHALL discard the partial and pending blocks without emitting them.
REQ-022 in_ready SHALL be 0 during reset cycles.

Verification
REQ-023 The bench SHALL cover these scenarios with defaults, MSB_FIRST=1 unless noted:
  - Full block: 16 units 0x00..0x0F with out_ready=1 -> out_valid one cycle after the last unit, out_data=128'h000102...0F, out_count=16.
  - Backpressure: out_ready=0, stream 32 units 0x00..0x1F -> first block held stable, in_ready drops after unit 0x1F (STALL). Raising out_ready delivers block 0x00..0x0F, then 0x10..0x1F, with no loss and no duplication.
  - Flush: 3 units AA,BB,CC then flush, PAD_BYTE=0x00 -> out_data=128'hAABBCC00...00, out_count=3. With MSB_FIRST=0, out_data[23:0]=24'hCCBBAA.
  - Flush with last unit: flush asserted together with the 16th unit -> exactly one block, out_count=16. Flush in EMPTY -> no out_valid.
  - Enable drop: 5 units, Enable=0 for one cycle, then 16 units 0x20..0x2F -> one block 0x20..0x2F; the first 5 units are absent.
  - Reset mid-stream: Rst after 7 units with a pending unread block -> out_valid=0 and fill_level=0 next cycle; the following 16 units form a clean block.

Source files
------------

// File: rtl/byte_block_packer.sv
// Packs a stream of BYTE_W units into NUM_BYTES-wide blocks; flush emits a padded partial block.
// Block valid one cycle after its last unit; filling continues while a block waits; in_ready drops only when both registers are full.
module byte_block_packer #(
  parameter int BYTE_W = 8,
  parameter int NUM_BYTES = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] PAD_BYTE = '0
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Enable,
  input  logic [BYTE_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [NUM_BYTES*BYTE_W-1:0]       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_BYTES+1)-1:0]    out_count,
  output logic [$clog2(NUM_BYTES+1)-1:0]    fill_level
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam int BLK_W = NUM_BYTES * BYTE_W;

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_STALL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic [BYTE_W-1:0]  acc_q [NUM_BYTES];
  logic [BYTE_W-1:0]  acc_d [NUM_BYTES];
  logic [BYTE_W-1:0]  acc_w [NUM_BYTES];
  logic [BLK_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               accept;
  logic               out_free;
  logic               blk_done;
  logic [CNT_W-1:0]   fill_inc;
  logic [BLK_W-1:0]   blk_flat;

  assign in_ready   = Enable && !Rst && (state_q != S_STALL);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign fill_level = fill_q;

  // Unused accumulator slots always hold PAD_BYTE, so a flushed block needs no masking.
  always_comb begin
    accept   = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    fill_inc = fill_q + CNT_W'(accept);

    for (int i = 0; i < NUM_BYTES; i++) begin
      acc_w[i] = acc_q[i];
      if (accept && (fill_q == CNT_W'(i))) acc_w[i] = in_data;
    end

    blk_flat = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (MSB_FIRST) blk_flat[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W] = acc_w[i];
      else           blk_flat[i*BYTE_W +: BYTE_W]               = acc_w[i];
    end

    blk_done = (state_q != S_STALL) &&
               ((fill_inc == CNT_W'(NUM_BYTES)) || (flush && (state_q == S_FILLING)));

    state_d     = state_q;
    fill_d      = fill_q;
    pend_cnt_d  = pend_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (!Enable) begin
      state_d    = S_EMPTY;
      fill_d     = '0;
      pend_cnt_d = '0;
      for (int i = 0; i < NUM_BYTES; i++) acc_d[i] = PAD_BYTE;
    end else if ((state_q == S_STALL) || blk_done) begin
      if (out_free) begin
        out_data_d  = blk_flat;
        out_count_d = (state_q == S_STALL) ? pend_cnt_q : fill_inc;
        out_valid_d = 1'b1;
        state_d     = S_EMPTY;
        fill_d      = '0;
        pend_cnt_d  = '0;
        for (int i = 0; i < NUM_BYTES; i++) acc_d[i] = PAD_BYTE;
      end else if (state_q != S_STALL) begin
        // Real unit count is kept aside; fill_level reports the accumulator as full.
        acc_d      = acc_w;
        pend_cnt_d = fill_inc;
        fill_d     = CNT_W'(NUM_BYTES);
        state_d    = S_STALL;
      end
    end else begin
      acc_d   = acc_w;
      fill_d  = fill_inc;
      state_d = (fill_inc == '0) ? S_EMPTY : S_FILLING;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_EMPTY;
      fill_q      <= '0;
      pend_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      for (int i = 0; i < NUM_BYTES; i++) acc_q[i] <= PAD_BYTE;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      pend_cnt_q  <= pend_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      for (int i = 0; i < NUM_BYTES; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule
